// File: rtl/uart_chk_pkg.sv
// Shared types and constants for the UART RX frame checker.
//
// Contents:
//   chk_state_e         frame-check FSM state
//   PAR_EVEN / PAR_ODD  values of par_typ
//   STOP_1 / STOP_2     values of stop_cfg
package uart_chk_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWPar  = 3'd1,
        StWStp1 = 3'd2,
        StWStp2 = 3'd3,
        StDone  = 3'd4
    } chk_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic STOP_1 = 1'b0;
    localparam logic STOP_2 = 1'b1;

endpackage

// File: rtl/uart_frame_chk_sat_cnt.sv
// Saturating up-counter with synchronous clear.
//
// Ports:
//   clk  clock
//   rst  asynchronous active-low reset
//   clr  clear to zero; applied before inc in the same cycle
//   inc  count up by one, holding at all-ones
//   cnt  current count
module sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] base;

    always_comb begin
        // clr first, so a coincident inc lands on zero and yields 1
        base  = clr ? '0 : cnt_q;
        cnt_d = base;
        if (inc && (base != {W{1'b1}})) begin
            cnt_d = base + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/uart_frame_chk.sv
// UART RX frame checker: validates the optional parity bit and one or two
// stop bits of each frame, driven by strobes from the RX control FSM.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   frm_start            start-bit seen: latch config, clear per-frame flags
//   chk_en, sampled_bit  next parity/stop bit is valid
//   data                 deserialised data word
//   par_en, par_typ      parity present, 0 even / 1 odd
//   stop_cfg             0 one stop bit, 1 two stop bits
//   err_clr              clear sticky flags and counters
//   frm_done             one-cycle pulse when a frame check completes
//   par_err, stp_err     errors of the last frame, held until next frm_start
//   par_sticky, stp_sticky, par_cnt, stp_cnt  accumulated error status
//   brk_det              break frame seen (pulses with frm_done)
//
// Build option: define UART_FRAME_CHK_BREAK_EN to recognise an all-zero
// frame as a break rather than a stop/parity error.
module uart_frame_chk
    import uart_chk_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned STOP_MAX = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frm_start,
    input  logic              chk_en,
    input  logic              sampled_bit,
    input  logic [DATA_W-1:0] data,
    input  logic              par_en,
    input  logic              par_typ,
    input  logic              stop_cfg,
    input  logic              err_clr,
    output logic              frm_done,
    output logic              par_err,
    output logic              stp_err,
    output logic              par_sticky,
    output logic              stp_sticky,
    output logic [CNT_W-1:0]  par_cnt,
    output logic [CNT_W-1:0]  stp_cnt,
    output logic              brk_det
);

    chk_state_e state_q, state_d;
    // par_en needs no register of its own: entering StWPar is its record.
    logic par_typ_q, par_typ_d;
    logic stop_cfg_q, stop_cfg_d;
    logic par_err_q, par_err_d;
    logic stp_err_q, stp_err_d;
    logic par_sticky_q, par_sticky_d;
    logic stp_sticky_q, stp_sticky_d;
    logic done;

`ifdef UART_FRAME_CHK_BREAK_EN
    logic brk_q, brk_d;
    logic par_zero_q, par_zero_d;  // parity bit absent or sampled as 0
`endif

    assign done = (state_q == StDone);

    always_comb begin
        state_d    = state_q;
        par_typ_d  = par_typ_q;
        stop_cfg_d = stop_cfg_q;
        par_err_d  = par_err_q;
        stp_err_d  = stp_err_q;
`ifdef UART_FRAME_CHK_BREAK_EN
        brk_d      = brk_q;
        par_zero_d = par_zero_q;
`endif

        unique case (state_q)
            StIdle: begin
                state_d = StIdle;
            end
            StWPar: begin
                if (chk_en) begin
                    par_err_d = (^data) ^ par_typ_q ^ sampled_bit;
`ifdef UART_FRAME_CHK_BREAK_EN
                    par_zero_d = ~sampled_bit;
`endif
                    state_d = StWStp1;
                end
            end
            StWStp1: begin
                if (chk_en) begin
                    stp_err_d = ~sampled_bit;
`ifdef UART_FRAME_CHK_BREAK_EN
                    // Break is decided on the first stop bit; it masks both errors.
                    if ((data == '0) && par_zero_q && !sampled_bit) begin
                        brk_d     = 1'b1;
                        par_err_d = 1'b0;
                        stp_err_d = 1'b0;
                    end
`endif
                    state_d = (stop_cfg_q == STOP_2) ? StWStp2 : StDone;
                end
            end
            StWStp2: begin
                if (chk_en) begin
                    stp_err_d = stp_err_q | ~sampled_bit;
`ifdef UART_FRAME_CHK_BREAK_EN
                    if (brk_q) begin
                        stp_err_d = 1'b0;
                    end
`endif
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A start from any state (re)starts the frame; in StDone the counter
        // update still happens this edge because it keys off state_q.
        if (frm_start) begin
            par_typ_d  = par_typ;
            stop_cfg_d = (STOP_MAX >= 2) ? stop_cfg : STOP_1;
            par_err_d  = 1'b0;
            stp_err_d  = 1'b0;
            state_d    = par_en ? StWPar : StWStp1;
`ifdef UART_FRAME_CHK_BREAK_EN
            brk_d      = 1'b0;
            par_zero_d = 1'b1;
`endif
        end
    end

    always_comb begin
        par_sticky_d = (err_clr ? 1'b0 : par_sticky_q) | (done & par_err_q);
        stp_sticky_d = (err_clr ? 1'b0 : stp_sticky_q) | (done & stp_err_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            par_typ_q    <= 1'b0;
            stop_cfg_q   <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            par_sticky_q <= 1'b0;
            stp_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            par_typ_q    <= par_typ_d;
            stop_cfg_q   <= stop_cfg_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
            par_sticky_q <= par_sticky_d;
            stp_sticky_q <= stp_sticky_d;
        end
    end

`ifdef UART_FRAME_CHK_BREAK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            brk_q      <= 1'b0;
            par_zero_q <= 1'b0;
        end else begin
            brk_q      <= brk_d;
            par_zero_q <= par_zero_d;
        end
    end

    assign brk_det = done & brk_q;
`else
    assign brk_det = 1'b0;
`endif

    sat_cnt #(
        .W (CNT_W)
    ) u_par_cnt (
        .clk (clk),
        .rst (rst),
        .clr (err_clr),
        .inc (done & par_err_q),
        .cnt (par_cnt)
    );

    sat_cnt #(
        .W (CNT_W)
    ) u_stp_cnt (
        .clk (clk),
        .rst (rst),
        .clr (err_clr),
        .inc (done & stp_err_q),
        .cnt (stp_cnt)
    );

    assign frm_done   = done;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;
    assign par_sticky = par_sticky_q;
    assign stp_sticky = stp_sticky_q;

endmodule

// File: tb/tb_uart_frame_chk.sv
// Self-checking bench for uart_frame_chk: directed cases plus randomized
// frames compared against a frame-level reference model.
module tb_uart_frame_chk;
    import uart_chk_pkg::*;

    localparam int unsigned DW   = 8;
    localparam int unsigned CW   = 2;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          frm_start, chk_en, sampled_bit, par_en, par_typ, stop_cfg, err_clr;
    logic [DW-1:0] data;
    logic          frm_done, par_err, stp_err, par_sticky, stp_sticky, brk_det;
    logic [CW-1:0] par_cnt, stp_cnt;

    always #5 clk = ~clk;

    uart_frame_chk #(
        .DATA_W   (DW),
        .CNT_W    (CW),
        .STOP_MAX (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frm_start   (frm_start),
        .chk_en      (chk_en),
        .sampled_bit (sampled_bit),
        .data        (data),
        .par_en      (par_en),
        .par_typ     (par_typ),
        .stop_cfg    (stop_cfg),
        .err_clr     (err_clr),
        .frm_done    (frm_done),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .par_sticky  (par_sticky),
        .stp_sticky  (stp_sticky),
        .par_cnt     (par_cnt),
        .stp_cnt     (stp_cnt),
        .brk_det     (brk_det)
    );

    typedef struct {
        bit            pen;
        bit            ptyp;
        bit            scfg;
        logic [DW-1:0] d;
        bit            pb;
        bit            s1;
        bit            s2;
    } frame_t;

    int n_err = 0;
    int n_chk = 0;

    // reference status
    int m_pcnt = 0;
    int m_scnt = 0;
    bit m_pst  = 0;
    bit m_sst  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame-level rules: count ones for parity, stop bits must be 1.
    function automatic void expect_frame(input frame_t f, output bit pe, output bit se,
                                         output bit brk);
        int ones = 0;
        for (int i = 0; i < int'(DW); i++) ones += int'(f.d[i]);
        pe  = f.pen && (((ones + int'(f.pb)) % 2) != (f.ptyp ? 1 : 0));
        se  = !f.s1 || (f.scfg && !f.s2);
        brk = 1'b0;
`ifdef UART_FRAME_CHK_BREAK_EN
        if ((f.d == '0) && (!f.pen || !f.pb) && !f.s1) begin
            brk = 1'b1;
            pe  = 1'b0;
            se  = 1'b0;
        end
`endif
    endfunction

    function automatic frame_t mk(input bit pen, input bit ptyp, input bit scfg,
                                  input logic [DW-1:0] d, input bit pb, input bit s1,
                                  input bit s2);
        frame_t f;
        f.pen = pen; f.ptyp = ptyp; f.scfg = scfg; f.d = d;
        f.pb = pb; f.s1 = s1; f.s2 = s2;
        return f;
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        bit     pb_ok;
        f.pen  = 1'($urandom);
        f.ptyp = 1'($urandom);
        f.scfg = 1'($urandom);
        f.d    = ($urandom_range(7, 0) == 0) ? '0 : DW'($urandom);
        pb_ok  = (^f.d) ^ f.ptyp;
        f.pb   = ($urandom_range(3, 0) == 0) ? ~pb_ok : pb_ok;
        f.s1   = ($urandom_range(3, 0) != 0);
        f.s2   = ($urandom_range(3, 0) != 0);
        return f;
    endfunction

    task automatic check_status(input string tag);
        check_eq({tag, "_pcnt"}, 32'(par_cnt), m_pcnt);
        check_eq({tag, "_scnt"}, 32'(stp_cnt), m_scnt);
        check_eq({tag, "_pst"}, 32'(par_sticky), 32'(m_pst));
        check_eq({tag, "_sst"}, 32'(stp_sticky), 32'(m_sst));
    endtask

    // Called and returns at posedge+1. started: frm_start already issued.
    // abort: restart after the first check bit (needs >1 check bit).
    // overlap: issue nxt's frm_start in the DONE cycle.
    task automatic send_frame(input frame_t f, input bit started, input bit abort,
                              input bit overlap, input frame_t nxt, input bit clr);
        bit bits[$];
        bit pe, se, brk;
        data = f.d;
        if (!started) begin
            frm_start = 1'b1; chk_en = 1'b0; err_clr = 1'b0;
            par_en = f.pen; par_typ = f.ptyp; stop_cfg = f.scfg;
            @(negedge clk);
            check_eq("done_pre_start", 32'(frm_done), 0);
            @(posedge clk); #1;
            frm_start = 1'b0;
        end
        // config changes mid-frame must be ignored
        par_en = 1'($urandom); par_typ = 1'($urandom); stop_cfg = 1'($urandom);
        if (f.pen) bits.push_back(f.pb);
        bits.push_back(f.s1);
        if (f.scfg) bits.push_back(f.s2);
        foreach (bits[i]) begin
            repeat ($urandom_range(2, 0)) begin
                chk_en = 1'b0; sampled_bit = 1'($urandom);
                @(negedge clk);
                check_eq("done_gap", 32'(frm_done), 0);
                @(posedge clk); #1;
            end
            chk_en = 1'b1; sampled_bit = bits[i];
            @(negedge clk);
            check_eq("done_wait", 32'(frm_done), 0);
            @(posedge clk); #1;
            chk_en = 1'b0;
            if (abort && (i == 0) && (bits.size() > 1)) return;
        end
        expect_frame(f, pe, se, brk);
        chk_en = 1'($urandom); sampled_bit = 1'($urandom);
        err_clr = clr; frm_start = overlap;
        if (overlap) begin
            par_en = nxt.pen; par_typ = nxt.ptyp; stop_cfg = nxt.scfg;
        end
        @(negedge clk);
        check_eq("frm_done", 32'(frm_done), 1);
        check_eq("par_err", 32'(par_err), 32'(pe));
        check_eq("stp_err", 32'(stp_err), 32'(se));
        check_eq("brk_det", 32'(brk_det), 32'(brk));
        if (clr) begin
            m_pcnt = 0; m_scnt = 0; m_pst = 1'b0; m_sst = 1'b0;
        end
        if (pe) begin m_pst = 1'b1; if (m_pcnt < CMAX) m_pcnt++; end
        if (se) begin m_sst = 1'b1; if (m_scnt < CMAX) m_scnt++; end
        @(posedge clk); #1;
        frm_start = 1'b0; err_clr = 1'b0;
        chk_en = overlap ? 1'b0 : 1'($urandom); sampled_bit = 1'($urandom);
        @(negedge clk);
        check_eq("done_low", 32'(frm_done), 0);
        check_eq("brk_low", 32'(brk_det), 0);
        check_eq("par_err_hold", 32'(par_err), overlap ? 0 : 32'(pe));
        check_eq("stp_err_hold", 32'(stp_err), overlap ? 0 : 32'(se));
        check_status("post");
        @(posedge clk); #1;
        chk_en = 1'b0;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        m_pcnt = 0; m_scnt = 0; m_pst = 1'b0; m_sst = 1'b0;
        @(negedge clk);
        check_status("clr");
        @(posedge clk); #1;
    endtask

    initial begin
        frame_t cur, nxt, none;
        bit     started, ov, ab;
        int     sat_exp[5] = '{1, 2, 3, 3, 1};

        none = mk(0, 0, 0, '0, 0, 1, 1);
        rst = 1'b0; frm_start = 1'b0; chk_en = 1'b0; sampled_bit = 1'b0; data = '0;
        par_en = 1'b0; par_typ = 1'b0; stop_cfg = 1'b0; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_done", 32'(frm_done), 0);
        check_eq("rst_perr", 32'(par_err), 0);
        check_eq("rst_serr", 32'(stp_err), 0);
        check_eq("rst_brk", 32'(brk_det), 0);
        check_status("rst");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // clean even-parity frame, then same with a bad parity bit
        send_frame(mk(1, PAR_EVEN, STOP_1, 8'hA5, 0, 1, 1), 0, 0, 0, none, 0);
        check_eq("t1_pcnt", 32'(par_cnt), 0);
        send_frame(mk(1, PAR_EVEN, STOP_1, 8'hA5, 1, 1, 1), 0, 0, 0, none, 0);
        check_eq("t2_pcnt", 32'(par_cnt), 1);
        check_eq("t2_pst", 32'(par_sticky), 1);
        // two stop bits, second bad; then one good stop bit
        send_frame(mk(0, 0, STOP_2, 8'h3C, 0, 1, 0), 0, 0, 0, none, 0);
        check_eq("t3_scnt", 32'(stp_cnt), 1);
        send_frame(mk(0, 0, STOP_1, 8'h3C, 0, 1, 1), 0, 0, 0, none, 0);
        check_eq("t4_scnt", 32'(stp_cnt), 1);
        clear_errs();

        // saturation, with err_clr on the fifth DONE
        for (int i = 0; i < 5; i++) begin
            send_frame(mk(0, 0, STOP_1, 8'h11, 0, 0, 1), 0, 0, 0, none, i == 4);
            check_eq("sat_scnt", 32'(stp_cnt), sat_exp[i]);
        end
        clear_errs();

        // abort in W_STP1 with a bad stop pending, then a clean frame
        send_frame(mk(1, PAR_ODD, STOP_2, 8'h5A, 0, 0, 0), 0, 1, 0, none, 0);
        send_frame(mk(1, PAR_ODD, STOP_1, 8'h5A, 1, 1, 1), 0, 0, 0, none, 0);
        check_eq("abort_scnt", 32'(stp_cnt), 0);
        check_eq("abort_pcnt", 32'(par_cnt), 0);

        // all-zero frame: break when enabled, otherwise a stop error
        send_frame(mk(1, PAR_EVEN, STOP_1, 8'h00, 0, 0, 0), 0, 0, 0, none, 0);
`ifdef UART_FRAME_CHK_BREAK_EN
        check_eq("brk_scnt", 32'(stp_cnt), 0);
`else
        check_eq("brk_scnt", 32'(stp_cnt), 1);
`endif

        // frm_start in DONE chains straight into the next frame
        nxt = mk(0, 0, STOP_2, 8'hF0, 0, 1, 0);
        send_frame(mk(1, PAR_ODD, STOP_1, 8'h01, 1, 0, 1), 0, 0, 1, nxt, 0);
        send_frame(nxt, 1, 0, 0, none, 0);

        // reset in the middle of a frame
        frm_start = 1'b1; par_en = 1'b1; par_typ = 1'b0; stop_cfg = 1'b1; data = 8'h01;
        @(posedge clk); #1;
        frm_start = 1'b0; chk_en = 1'b1; sampled_bit = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_eq("mrst_perr", 32'(par_err), 0);
        check_eq("mrst_done", 32'(frm_done), 0);
        m_pcnt = 0; m_scnt = 0; m_pst = 1'b0; m_sst = 1'b0;
        check_status("mrst");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        send_frame(mk(0, 0, STOP_1, 8'h77, 0, 1, 1), 0, 0, 0, none, 0);

        // randomized frames
        cur = rand_frame();
        started = 1'b0;
        for (int n = 0; n < 200; n++) begin
            nxt = rand_frame();
            ab  = ($urandom_range(7, 0) == 0) && (cur.pen || cur.scfg) && !started;
            ov  = !ab && ($urandom_range(3, 0) == 0);
            send_frame(cur, started, ab, ov, nxt, $urandom_range(7, 0) == 0);
            started = ov;
            cur = nxt;
        end
        if (started) send_frame(cur, 1, 0, 0, none, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
